// File: rtl/noc_traffic_pe.sv
// noc_traffic_pe: traffic generator plus sink for one router local port.
// Latency statistics are built only with NOC_PE_LATENCY_STATS_EN defined.
module noc_traffic_pe #(
    parameter int ADDRESS    = 0,
    parameter int ADDR_WIDTH = 4,
    parameter int TS_WIDTH   = 32,
    parameter int PKT_LIMIT  = 20,
    parameter int FLIT_WIDTH = 3 + 2*ADDR_WIDTH + TS_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [2:0]            i_mode,
    input  logic [7:0]            i_gap,
    input  logic                  i_clr_stats,
    output logic [FLIT_WIDTH-1:0] o_data,
    output logic                  o_data_valid,
    input  logic                  i_data_ready,
    input  logic [FLIT_WIDTH-1:0] i_data,
    input  logic                  i_data_valid,
    output logic                  o_data_ready,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [15:0]           o_tx_count,
    output logic [15:0]           o_rx_count,
    output logic [31:0]           o_lat_sum,
    output logic [TS_WIDTH-1:0]   o_lat_max
);

    localparam int NUM_PE = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] SRC = ADDR_WIDTH'(ADDRESS);
    localparam logic [15:0] SEED  = 16'(ADDRESS + 1);
    localparam logic [15:0] LIMIT = 16'(PKT_LIMIT);
    localparam logic [ADDR_WIDTH-1:0] TORN =
        ADDR_WIDTH'((ADDRESS + (NUM_PE + 1) / 2) % NUM_PE);
    localparam logic [ADDR_WIDTH-1:0] NEIGH =
        ADDR_WIDTH'((ADDRESS + 1) % NUM_PE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [TS_WIDTH-1:0]   ts_q, ts_d;
    logic [15:0]           lfsr_q, lfsr_d;
    logic [2:0]            mode_q, mode_d;
    logic [7:0]            gap_q, gap_d;
    logic [7:0]            gcnt_q, gcnt_d;
    logic [15:0]           tx_q, tx_d;
    logic [FLIT_WIDTH-1:0] data_q, data_d;
    logic [15:0]           lfsr_adv;
    logic [2:0]            mode_sel;
    logic [ADDR_WIDTH-1:0] dest;
    logic                  hs;
    logic                  load;

    // Fixed bit-permutation destinations depend only on ADDRESS.
    logic [ADDR_WIDTH-1:0] d_comp, d_rev, d_rot, d_trn;
    for (genvar j = 0; j < ADDR_WIDTH; j++) begin : g_perm
        assign d_comp[j] = ~SRC[j];
        assign d_rev[j]  = SRC[ADDR_WIDTH-1-j];
        assign d_rot[j]  = SRC[(j+1)%ADDR_WIDTH];
        assign d_trn[j]  = SRC[(j+ADDR_WIDTH/2)%ADDR_WIDTH];
    end

    assign hs       = (state_q == S_SEND) & i_data_ready;
    assign ts_d     = ts_q + 1'b1;
    assign lfsr_adv = {lfsr_q[14:0],
                       lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign lfsr_d   = hs ? lfsr_adv : lfsr_q;

    // Generator next state, counters and flit load request.
    always_comb begin
        state_d  = state_q;
        tx_d     = tx_q;
        gcnt_d   = gcnt_q;
        mode_d   = mode_q;
        gap_d    = gap_q;
        mode_sel = mode_q;
        load     = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    state_d  = S_SEND;
                    tx_d     = '0;
                    mode_d   = i_mode;
                    gap_d    = i_gap;
                    mode_sel = i_mode;
                    load     = 1'b1;
                end
            end
            S_SEND: begin
                if (hs) begin
                    tx_d = tx_q + 1'b1;
                    if (tx_d == LIMIT) begin
                        state_d = S_DONE;
                    end else if (gap_q == 8'd0) begin
                        load = 1'b1;
                    end else begin
                        state_d = S_GAP;
                        gcnt_d  = gap_q;
                    end
                end
            end
            S_GAP: begin
                if (gcnt_q == 8'd1) begin
                    state_d = S_SEND;
                    load    = 1'b1;
                end else begin
                    gcnt_d = gcnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Destination of the flit being loaded, using the post-handshake LFSR.
    always_comb begin
        dest = lfsr_d[ADDR_WIDTH-1:0];
        case (mode_sel)
            3'd0:    dest = lfsr_d[ADDR_WIDTH-1:0];
            3'd1:    dest = d_comp;
            3'd2:    dest = d_rev;
            3'd3:    dest = d_rot;
            3'd4:    dest = d_trn;
            3'd5:    dest = TORN;
            default: dest = NEIGH;
        endcase
    end

    // Timestamp is the counter value in the flit's first valid cycle.
    assign data_d = load ? {1'b1, 1'b1, dest, 1'b0, SRC, ts_d} : data_q;

    // Generator state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ts_q    <= '0;
            lfsr_q  <= SEED;
            mode_q  <= '0;
            gap_q   <= '0;
            gcnt_q  <= '0;
            tx_q    <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ts_q    <= ts_d;
            lfsr_q  <= lfsr_d;
            mode_q  <= mode_d;
            gap_q   <= gap_d;
            gcnt_q  <= gcnt_d;
            tx_q    <= tx_d;
            data_q  <= data_d;
        end
    end

    assign o_data       = data_q;
    assign o_data_valid = (state_q == S_SEND);
    assign o_busy       = (state_q == S_SEND) | (state_q == S_GAP);
    assign o_done       = (state_q == S_DONE);
    assign o_tx_count   = tx_q;
    assign o_data_ready = 1'b1;

    logic [15:0] rx_q;

    // Received flit counter; a clear beats a coincident flit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_q <= '0;
        end else if (i_clr_stats) begin
            rx_q <= '0;
        end else if (i_data_valid) begin
            rx_q <= rx_q + 1'b1;
        end
    end

    assign o_rx_count = rx_q;

`ifdef NOC_PE_LATENCY_STATS_EN
    logic [TS_WIDTH-1:0] lat;
    logic [31:0]         lat_sum_q;
    logic [TS_WIDTH-1:0] lat_max_q;

    assign lat = ts_q - i_data[TS_WIDTH-1:0];

    // Latency accumulation and running maximum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_sum_q <= '0;
            lat_max_q <= '0;
        end else if (i_clr_stats) begin
            lat_sum_q <= '0;
            lat_max_q <= '0;
        end else if (i_data_valid) begin
            lat_sum_q <= lat_sum_q + 32'(lat);
            if (lat > lat_max_q) lat_max_q <= lat;
        end
    end

    assign o_lat_sum = lat_sum_q;
    assign o_lat_max = lat_max_q;
`else
    assign o_lat_sum = '0;
    assign o_lat_max = '0;
`endif

    logic unused_data;
    assign unused_data = ^i_data;

endmodule

// File: tb/tb_noc_traffic_pe.sv
// tb_noc_traffic_pe: scoreboard bench for noc_traffic_pe.
// Covers all patterns, backpressure, gap timing, sink stats and reset abort.
module tb_noc_traffic_pe;

    localparam int AW = 4;
    localparam int TW = 32;
    localparam int FW = 3 + 2*AW + TW;
    localparam logic [3:0] SRC = 4'd3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_start = 1'b0;
    logic          s4 = 1'b0;
    logic [2:0]    i_mode = '0;
    logic [7:0]    i_gap = '0;
    logic          i_clr_stats = 1'b0;
    logic          i_data_ready = 1'b1;
    logic          lb = 1'b0;
    logic          inj_valid = 1'b0;
    logic [FW-1:0] inj_data = '0;
    logic [FW-1:0] i_data;
    logic          i_data_valid;

    logic [FW-1:0] o_data, o4_data;
    logic          o_data_valid, o4_valid;
    logic          o_data_ready, o4_ready;
    logic          o_busy, o4_busy, o_done, o4_done;
    logic [15:0]   o_tx_count, o4_tx, o_rx_count, o4_rx;
    logic [31:0]   o_lat_sum, o4_lsum;
    logic [TW-1:0] o_lat_max, o4_lmax;

    assign i_data       = lb ? o_data : inj_data;
    assign i_data_valid = lb ? (o_data_valid & i_data_ready) : inj_valid;

    noc_traffic_pe #(.ADDRESS(3), .ADDR_WIDTH(AW), .TS_WIDTH(TW),
                     .PKT_LIMIT(20)) u_dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_mode(i_mode),
        .i_gap(i_gap), .i_clr_stats(i_clr_stats), .o_data(o_data),
        .o_data_valid(o_data_valid), .i_data_ready(i_data_ready),
        .i_data(i_data), .i_data_valid(i_data_valid),
        .o_data_ready(o_data_ready), .o_busy(o_busy), .o_done(o_done),
        .o_tx_count(o_tx_count), .o_rx_count(o_rx_count),
        .o_lat_sum(o_lat_sum), .o_lat_max(o_lat_max));

    noc_traffic_pe #(.ADDRESS(3), .ADDR_WIDTH(AW), .TS_WIDTH(TW),
                     .PKT_LIMIT(4)) u_dut4 (
        .clk(clk), .rst(rst), .i_start(s4), .i_mode(i_mode),
        .i_gap(i_gap), .i_clr_stats(i_clr_stats), .o_data(o4_data),
        .o_data_valid(o4_valid), .i_data_ready(i_data_ready),
        .i_data(i_data), .i_data_valid(i_data_valid),
        .o_data_ready(o4_ready), .o_busy(o4_busy), .o_done(o4_done),
        .o_tx_count(o4_tx), .o_rx_count(o4_rx),
        .o_lat_sum(o4_lsum), .o_lat_max(o4_lmax));

    always #5 clk = ~clk;

    logic [TW-1:0] tb_ts;
    always @(posedge clk or posedge rst) begin
        if (rst) tb_ts <= '0;
        else     tb_ts <= tb_ts + 1'b1;
    end

    int checks = 0;
    int failures = 0;
    logic [3:0]  sb[$];
    logic [15:0] mdl;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] step(input logic [15:0] m);
        return {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};
    endfunction

    task automatic push_run(input int mode, input int n);
        logic [3:0] d;
        for (int i = 0; i < n; i++) begin
            case (mode)
                0:       d = mdl[3:0];
                1:       d = 4'd12;
                2:       d = 4'd12;
                3:       d = 4'd9;
                4:       d = 4'd12;
                5:       d = 4'd11;
                default: d = 4'd4;
            endcase
            sb.push_back(d);
            mdl = step(mdl);
        end
    endtask

    task automatic start_run(input int mode, input int gap);
        @(negedge clk);
        i_mode  = 3'(mode);
        i_gap   = 8'(gap);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        i_mode  = 3'(mode + 1);
        i_gap   = 8'(gap + 2);
    endtask

    function automatic logic [63:0] flit(input logic [3:0] d,
                                         input logic [TW-1:0] ts);
        return 64'({2'b11, d, 1'b0, SRC, ts});
    endfunction

    task automatic run_check(input int n);
        int first, last, done_at, nv;
        logic [3:0] e;
        first = -1; last = -1; done_at = -1; nv = 0;
        for (int c = 0; c < 200; c++) begin
            if (o_data_valid && i_data_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_empty", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("flit", 64'(o_data), flit(e, tb_ts));
                end
                if (first < 0) first = c;
                last = c;
                nv++;
            end
            if (o_done) begin
                done_at = c;
                break;
            end
            @(negedge clk);
        end
        chk("nvalid", nv, n);
        chk("contig", last - first + 1, n);
        chk("done_lat", done_at, last + 1);
        chk("tx_count", o_tx_count, 20);
        chk("busy_done", o_busy, 0);
    endtask

    task automatic chk_reset_outs();
        chk("rst_data", 64'(o_data), 0);
        chk("rst_valid", o_data_valid, 0);
        chk("rst_ready", o_data_ready, 1);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_tx", o_tx_count, 0);
        chk("rst_rx", o_rx_count, 0);
        chk("rst_lsum", o_lat_sum, 0);
        chk("rst_lmax", 64'(o_lat_max), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int vs[$];
        int done_at;
        int lsum_exp, lmax_exp;
        logic [3:0] e;
        logic [TW-1:0] tsx;
        mdl = 16'd4;
        #12;
        chk_reset_outs();
        @(negedge clk);
        rst = 1'b0;

        // Loopback RANDOM run straight after reset.
        lb = 1'b1;
        push_run(0, 20);
        start_run(0, 0);
        run_check(20);
        chk("lb_rx", o_rx_count, 20);
        chk("lb_lsum", o_lat_sum, 0);
        chk("lb_lmax", 64'(o_lat_max), 0);
        lb = 1'b0;

        // Every fixed pattern, restarting from DONE.
        for (int m = 1; m < 8; m++) begin
            push_run(m, 20);
            start_run(m, 0);
            run_check(20);
        end

        // Backpressure on the first flit for five cycles.
        i_data_ready = 1'b0;
        push_run(6, 20);
        start_run(6, 0);
        tsx = tb_ts;
        e = sb.pop_front();
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", o_data_valid, 1);
            chk("bp_data", 64'(o_data), flit(e, tsx));
            chk("bp_tx", o_tx_count, 0);
            @(negedge clk);
        end
        chk("bp_data6", 64'(o_data), flit(e, tsx));
        i_data_ready = 1'b1;
        @(negedge clk);
        chk("bp_tx1", o_tx_count, 1);
        run_check(19);

        // Gap of three on the four-packet instance.
        @(negedge clk);
        i_mode = 3'd1;
        i_gap  = 8'd3;
        s4     = 1'b1;
        @(negedge clk);
        s4     = 1'b0;
        i_gap  = 8'd0;
        done_at = -1;
        for (int c = 0; c < 60; c++) begin
            if (o4_valid) vs.push_back(c);
            if (o4_done) begin
                done_at = c;
                break;
            end
            @(negedge clk);
        end
        chk("gap_npulse", vs.size(), 4);
        if (vs.size() == 4) begin
            for (int i = 1; i < 4; i++)
                chk("gap_space", vs[i] - vs[i-1], 4);
            chk("gap_done", done_at, vs[3] + 1);
        end
        chk("gap_tx", o4_tx, 4);

        // Injected latencies of 7 and 2, then clear.
        @(negedge clk);
        i_clr_stats = 1'b1;
        @(negedge clk);
        i_clr_stats = 1'b0;
        chk("clr_rx0", o_rx_count, 0);
        inj_valid = 1'b1;
        inj_data  = {2'b11, 4'd0, 1'b0, 4'd0, tb_ts - 32'd7};
        @(negedge clk);
        inj_data  = {2'b11, 4'd0, 1'b0, 4'd0, tb_ts - 32'd2};
        @(negedge clk);
        inj_valid = 1'b0;
`ifdef NOC_PE_LATENCY_STATS_EN
        lsum_exp = 9;
        lmax_exp = 7;
`else
        lsum_exp = 0;
        lmax_exp = 0;
`endif
        chk("lat_rx", o_rx_count, 2);
        chk("lat_sum", o_lat_sum, 64'(lsum_exp));
        chk("lat_max", 64'(o_lat_max), 64'(lmax_exp));
        inj_valid   = 1'b1;
        i_clr_stats = 1'b1;
        @(negedge clk);
        inj_valid   = 1'b0;
        i_clr_stats = 1'b0;
        chk("clr_rx", o_rx_count, 0);
        chk("clr_sum", o_lat_sum, 0);
        chk("clr_max", 64'(o_lat_max), 0);

        // Abort at ten flits, then a fresh RANDOM run.
        start_run(0, 0);
        for (int c = 0; c < 50; c++) begin
            if (o_tx_count == 16'd10) break;
            @(negedge clk);
        end
        chk("abort_at10", o_tx_count, 10);
        #2 rst = 1'b1;
        #1;
        chk_reset_outs();
        @(negedge clk);
        rst = 1'b0;
        mdl = 16'd4;
        sb.delete();
        push_run(0, 20);
        start_run(0, 0);
        run_check(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/noc_traffic_pe.md
Name: noc_traffic_pe

Overview:
- Synthesizable, parametrised NoC traffic endpoint: a generator plus a sink attached to one router local port of the mesh.
- The generator injects up to PKT_LIMIT timestamped flits. Destinations follow a runtime-selectable pattern.
- Each flit is held under a proper valid/ready handshake, with a programmable inter-packet gap.
- The sink accepts flits, counts them and measures network latency in hardware, so stats are readable without simulation file I/O.

Parameters:
- ADDRESS, 0, this PE's node address (0..NUM_PE-1).
- ADDR_WIDTH, 4, destination/source field width; NUM_PE = 2**ADDR_WIDTH.
- TS_WIDTH, 32, timestamp width.
- PKT_LIMIT, 20, packets per run (1..65535).
- FLIT_WIDTH, 3+2*ADDR_WIDTH+TS_WIDTH, derived; do not override.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- i_start  in  1  1-cycle pulse; starts a run
- i_mode  in  3  pattern: 0 RANDOM, 1 COMPLEMENT, 2 REVERSE, 3 ROTATION, 4 TRANSPOSE, 5 TORNADO, 6/7 NEIGHBOUR
- i_gap  in  8  idle cycles between accepted flits
- i_clr_stats  in  1  synchronous clear of rx statistics
- o_data  out  FLIT_WIDTH  {1'b1,1'b1,dest,1'b0,src=ADDRESS,ts}
- o_data_valid  out  1  flit valid
- i_data_ready  in  1  router accepts flit
- i_data  in  FLIT_WIDTH  received flit
- i_data_valid  in  1  received flit valid
- o_data_ready  out  1  sink ready; constant 1
- o_busy  out  1  run in progress
- o_done  out  1  run complete
- o_tx_count  out  16  flits accepted this run
- o_rx_count  out  16  flits received; wraps
- o_lat_sum  out  32  sum of latencies; wraps mod 2**32
- o_lat_max  out  TS_WIDTH  maximum latency

Behaviour:
- Reset values:
  - All outputs 0, except o_data_ready = 1.
  - ts counter = 0.
  - LFSR = ADDRESS+1 (16-bit; never zero).
  - State = IDLE.
- ts counter: free-running, +1 every cycle, wraps at 2**TS_WIDTH.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances exactly once per accepted flit. RANDOM dest = lfsr[ADDR_WIDTH-1:0].
- Pattern rules, per bit j of dest (a = ADDRESS):
  - COMPLEMENT: ~a[j].
  - REVERSE: a[ADDR_WIDTH-1-j].
  - ROTATION: a[(j+1)%ADDR_WIDTH].
  - TRANSPOSE: a[(j+ADDR_WIDTH/2)%ADDR_WIDTH].
  - TORNADO: (a+(NUM_PE+1)/2) mod NUM_PE.
  - NEIGHBOUR: (a+1) mod NUM_PE.
- Mode sampling: i_mode and i_gap are latched on the accepted i_start. Later changes have no effect until the next run.
- FSM states: IDLE, SEND, GAP, DONE.
- IDLE:
  - i_start -> SEND; tx_count cleared; first flit loaded.
  - o_busy = 0.
- SEND:
  - o_data_valid = 1; o_data held stable until the handshake (o_data_valid & i_data_ready at a rising edge).
  - On handshake: tx_count+1.
    - If the new count == PKT_LIMIT -> DONE.
    - Else if gap == 0 -> stay in SEND; next flit presented the following cycle (back-to-back, 1 flit/cycle max).
    - Else -> GAP with gap counter = gap.
- GAP:
  - o_data_valid = 0.
  - Counter decrements each cycle; when it reaches 1 -> SEND, loading a new flit.
- DONE:
  - o_done = 1, o_busy = 0.
  - i_start restarts the run: o_done cleared, tx_count cleared, -> SEND.
- Flit timestamp: ts = ts-counter value during the first cycle the flit is valid. Backpressure stall time therefore counts toward latency.
- i_start during SEND/GAP: ignored.
- rst mid-run: immediate abort to IDLE; the in-flight flit is dropped; all counters and the LFSR return to reset values.
- Sink (every cycle with i_data_valid):
  - rx_count+1.
  - lat = (ts_counter - i_data[TS_WIDTH-1:0]) mod 2**TS_WIDTH.
  - lat_sum += lat; lat_max = max(lat_max, lat).
- i_clr_stats: zeroes rx_count, lat_sum and lat_max. If it coincides with i_data_valid, the clear wins and the flit is not counted.
- Sink operates independently of generator state, including IDLE and DONE.

Optional Feature:
- Macro: NOC_PE_LATENCY_STATS_EN.
- Defined: o_lat_sum and o_lat_max are computed as above.
- Undefined: both outputs are tied 0 and the subtractor/comparator/accumulators are not instantiated. o_rx_count still operates.

Test Plan:
- ADDRESS=3, ADDR_WIDTH=4, ready=1, i_gap=0, check each mode:
  - COMPLEMENT: dest 12 on all 20 flits.
  - REVERSE: 12; ROTATION: 9; TRANSPOSE: 12; TORNADO: 11; NEIGHBOUR: 4.
  - Each run: o_data_valid high for exactly 20 consecutive cycles, then o_done=1 and o_tx_count=20.
- Backpressure: hold i_data_ready=0 for 5 cycles with a flit pending.
  - Required: o_data stable and valid for all 5 cycles.
  - Handshake occurs on the 6th cycle; tx_count increments by exactly 1.
- i_gap=3, PKT_LIMIT=4: valid pulses exactly 1 cycle each, separated by exactly 3 idle cycles; o_done asserts one cycle after the 4th handshake.
- Loopback o_data->i_data, ready=1, RANDOM:
  - rx_count=20; lat_sum=0; lat_max=0.
  - dests equal the LFSR low nibble sequence from seed 4.
- Inject i_data with ts = ts_counter-7, then ts_counter-2: lat_sum=9, lat_max=7. Then i_clr_stats -> all three 0.
- Assert rst at tx_count=10 -> all outputs reset asynchronously. A subsequent i_start yields a fresh 20-flit run with the same RANDOM sequence as the first run.
